// File: rtl/serial_port_if.sv
// CPU device-bus side of the serial port: address, write/read strobes and data.
// The CPU (or bench) drives through master; the peripheral responds through slave.
interface serial_port_if;
    logic [7:0]  addr;
    logic [15:0] bus_in;
    logic        DI;
    logic        DO;
    logic [15:0] bus_out;
    logic        bus_oe;

    modport master (output addr, bus_in, DI, DO, input bus_out, bus_oe);
    modport slave  (input addr, bus_in, DI, DO, output bus_out, bus_oe);
endinterface

// File: rtl/serial_port.sv
// Byte-wide 8N1 UART on the CPU device bus: data register at BASE, status at BASE+1,
// with DEPTH-entry TX and RX FIFOs between the bus and the serial shifters.
module serial_port #(
    parameter logic [7:0]  BASE  = 8'h02,
    parameter int unsigned DIV   = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    serial_port_if.slave bus,
    output logic         tx,
    input  logic         rx
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------- bus decode ----------------
    logic sel_data, sel_stat, stat_rd;
    logic unused_bus_hi;

    assign sel_data      = (bus.addr == BASE);
    assign sel_stat      = (bus.addr == BASE + 8'd1);
    assign stat_rd       = bus.DO & sel_stat;
    assign bus.bus_oe    = bus.DO & (sel_data | sel_stat);
    assign unused_bus_hi = ^bus.bus_in[15:8];

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [DEPTH];
    logic [PW-1:0] tx_wp, tx_rp;
    logic          tx_empty, tx_full, tx_push, tx_pop;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW-1:0] == tx_rp[AW-1:0]) && (tx_wp[AW] != tx_rp[AW]);
    assign tx_push  = bus.DI & sel_data & ~tx_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) begin
                tx_mem[tx_wp[AW-1:0]] <= bus.bus_in[7:0];
                tx_wp <= tx_wp + 1'b1;
            end
            if (tx_pop)
                tx_rp <= tx_rp + 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    tx_state_t     tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_sh, tx_sh_n;
    logic          tx_last, tx_busy;

    assign tx_last = (tx_cnt == BIT_LAST);
    assign tx_busy = (tx_state != TX_IDLE) | ~tx_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 1'b1;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_sh_n    = tx_mem[tx_rp[AW-1:0]];
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_last) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_last) begin
                    tx_cnt_n = '0;
                    tx_sh_n  = {1'b0, tx_sh[7:1]};
                    tx_bit_n = tx_bit + 3'd1;
                    if (tx_bit == 3'd7)
                        tx_state_n = TX_STOP;
                end
            end
            TX_STOP: begin
                // Chain directly into the next frame so back-to-back bytes have no idle gap.
                if (tx_last) begin
                    tx_cnt_n = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_sh_n    = tx_mem[tx_rp[AW-1:0]];
                        tx_state_n = TX_START;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        if (tx_state == TX_START)
            tx = 1'b0;
        else if (tx_state == TX_DATA)
            tx = tx_sh[0];
    end

    // ---------------- RX synchroniser ----------------
    logic rx_s1, rx_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] rx_wp, rx_rp;
    logic          rx_empty, rx_full, rx_push, rx_pop;
    logic [7:0]    rx_sh;

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW-1:0] == rx_rp[AW-1:0]) && (rx_wp[AW] != rx_rp[AW]);
    assign rx_pop   = bus.DO & sel_data & ~rx_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wp[AW-1:0]] <= rx_sh;
                rx_wp <= rx_wp + 1'b1;
            end
            if (rx_pop)
                rx_rp <= rx_rp + 1'b1;
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t     rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_sh_n;
    logic          rx_last, ovr_set, ferr_set;

    assign rx_last = (rx_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_sh    <= rx_sh_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 1'b1;
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        rx_push    = 1'b0;
        ovr_set    = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (!rx_s2)
                    rx_state_n = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_last) begin
                    rx_cnt_n = '0;
                    rx_sh_n  = {rx_s2, rx_sh[7:1]};
                    rx_bit_n = rx_bit + 3'd1;
                    if (rx_bit == 3'd7)
                        rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                // A same-edge CPU pop frees a slot, so a full FIFO still accepts the byte.
                if (rx_last) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
                    if (!rx_s2)
                        ferr_set = 1'b1;
                    else if (rx_full && !rx_pop)
                        ovr_set = 1'b1;
                    else
                        rx_push = 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // ---------------- status flags ----------------
    logic ovr, ferr;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            if (stat_rd) begin
                ovr  <= 1'b0;
                ferr <= 1'b0;
            end
            if (ovr_set)
                ovr <= 1'b1;
            if (ferr_set)
                ferr <= 1'b1;
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        bus.bus_out = '0;
        if (bus.DO) begin
            if (sel_data && !rx_empty)
                bus.bus_out = {8'h00, rx_mem[rx_rp[AW-1:0]]};
            else if (sel_stat)
                bus.bus_out = {11'b0, ferr, ovr, tx_busy, tx_full, ~rx_empty};
        end
    end
endmodule

// File: tb/tb_serial_port.sv
// Scoreboard bench for serial_port: a cycle-level occupancy model predicts status and the
// accepted TX byte stream; monitors decode tx frames and check every bus read.
module tb_serial_port;
    localparam int unsigned  DIV   = 4;
    localparam int unsigned  DEPTH = 4;
    localparam logic [7:0]   BASE  = 8'h02;
    localparam logic [7:0]   STAT  = 8'h03;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic tx;

    serial_port_if bus ();

    serial_port #(.BASE(BASE), .DIV(DIV), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx),
        .rx    (rx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    int         tx_cnt_m  = 0;    // bytes waiting in the TX FIFO
    int         tx_left   = 0;    // clocks left in the frame on the wire
    logic [7:0] tx_exp [$];       // accepted bytes, in wire order
    logic [7:0] rx_m   [$];
    bit         ovr_m = 1'b0;
    bit         ferr_m = 1'b0;
    logic [15:0] rd_exp  [$];
    string       rd_name [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transmitter abstraction: a frame holds the line 10*DIV clocks; a new byte is
    // taken whenever the line is free and the queue is non-empty.
    always @(posedge clk) begin : tx_model
        int acc, pop;
        if (reset) begin
            tx_cnt_m = 0;
            tx_left  = 0;
            tx_exp.delete();
        end else begin
            if (tx_left > 0) tx_left--;
            pop = (tx_left == 0 && tx_cnt_m > 0) ? 1 : 0;
            acc = (bus.DI === 1'b1 && bus.addr == BASE && tx_cnt_m < int'(DEPTH)) ? 1 : 0;
            if (acc != 0) tx_exp.push_back(bus.bus_in[7:0]);
            tx_cnt_m = tx_cnt_m + acc - pop;
            if (pop != 0) tx_left = 10 * DIV;
        end
    end

    function automatic logic [15:0] status_m();
        logic busy, full;
        busy = (tx_left > 0) || (tx_cnt_m > 0);
        full = (tx_cnt_m == int'(DEPTH));
        return {11'b0, ferr_m, ovr_m, busy, full, rx_m.size() > 0};
    endfunction

    // bus read monitor
    always @(negedge clk) begin
        if (bus.bus_oe === 1'b1) begin
            if (rd_exp.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_read got=%h want=none", bus.bus_out);
            end else begin
                chk(rd_name.pop_front(), {16'h0, bus.bus_out}, {16'h0, rd_exp.pop_front()});
            end
        end
    end

    // tx line monitor: decode each frame and check every bit holds for DIV clocks
    initial begin : tx_mon
        logic [9:0] fr;
        bit abort, steady;
        logic [7:0] eb;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1 && tx === 1'b0) begin
                fr = '0;
                abort = 1'b0;
                steady = 1'b1;
                for (int i = 0; i < 10 && !abort; i++) begin
                    for (int j = 0; j < int'(DIV) && !abort; j++) begin
                        if (i != 0 || j != 0) @(negedge clk);
                        if (reset === 1'b1) abort = 1'b1;
                        else if (j == 0) fr[i] = tx;
                        else if (tx !== fr[i]) steady = 1'b0;
                    end
                end
                if (!abort) begin
                    if (tx_exp.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL tx_frame_unexpected got=%h want=none", fr);
                    end else begin
                        eb = tx_exp.pop_front();
                        chk("tx_frame", {21'h0, steady, fr}, {21'h0, 1'b1, 1'b1, eb, 1'b0});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_op(input bit di, input bit rd, input logic [7:0] a,
                          input logic [15:0] d, input string nm);
        logic [7:0] h;
        bus.DI = di;
        bus.DO = rd;
        bus.addr = a;
        bus.bus_in = d;
        if (rd) begin
            if (a == BASE) begin
                if (rx_m.size() > 0) begin
                    h = rx_m.pop_front();
                    rd_exp.push_back({8'h00, h});
                end else begin
                    rd_exp.push_back(16'h0000);
                end
                rd_name.push_back(nm);
            end else if (a == STAT) begin
                rd_exp.push_back(status_m());
                rd_name.push_back(nm);
                ovr_m = 1'b0;
                ferr_m = 1'b0;
            end
        end
        tick();
        bus.DI = 1'b0;
        bus.DO = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        rx_m.delete();
        ovr_m = 1'b0;
        ferr_m = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (DIV) tick();
        end
        rx = 1'b1;
        repeat (2 * DIV) tick();
        if (!stop_ok) ferr_m = 1'b1;
        else if (rx_m.size() < int'(DEPTH)) rx_m.push_back(b);
        else ovr_m = 1'b1;
    endtask

    task automatic rx_glitch();
        rx = 1'b0;
        tick();
        rx = 1'b1;
        repeat (3 * DIV) tick();
    endtask

    task automatic wait_tx_idle();
        int n;
        n = 0;
        while ((tx_left > 0 || tx_cnt_m > 0) && n < 3000) begin
            tick();
            n++;
        end
        chk("tx_drain_timeout", {31'h0, n < 3000}, 32'h1);
        repeat (2) tick();
    endtask

    initial begin
        bus.DI = 1'b0;
        bus.DO = 1'b0;
        bus.addr = '0;
        bus.bus_in = '0;
        do_reset(3);
        tick();

        // T1: reset state and one frame
        chk("reset_tx", {31'h0, tx}, 32'h1);
        bus_op(0, 1, STAT, 16'h0, "reset_status");
        bus_op(1, 0, BASE, 16'h1241, "");
        bus_op(0, 1, STAT, 16'h0, "t1_busy_status");
        wait_tx_idle();
        bus_op(0, 1, STAT, 16'h0, "t1_idle_status");

        // T2: burst of 6, the last one dropped
        for (int i = 1; i <= 6; i++)
            bus_op(1, 0, BASE, {8'($urandom), 8'(i)}, "");
        bus_op(0, 1, STAT, 16'h0, "t2_full_status");
        wait_tx_idle();
        bus_op(0, 1, STAT, 16'h0, "t2_idle_status");

        // T3: single rx byte
        rx_frame(8'h5A, 1'b1);
        bus_op(0, 1, STAT, 16'h0, "t3_avail_status");
        bus_op(0, 1, BASE, 16'h0, "t3_data");
        bus_op(0, 1, STAT, 16'h0, "t3_empty_status");
        bus_op(0, 1, BASE, 16'h0, "t3_empty_data");

        // T4: overrun
        for (int i = 0; i < 5; i++)
            rx_frame(8'(8'h10 + i), 1'b1);
        bus_op(0, 1, STAT, 16'h0, "t4_ovr_status");
        for (int i = 0; i < 4; i++)
            bus_op(0, 1, BASE, 16'h0, "t4_data");
        bus_op(0, 1, STAT, 16'h0, "t4_cleared_status");
        bus_op(0, 1, BASE, 16'h0, "t4_empty_data");

        // T5: framing error and a one-clock glitch
        rx_frame(8'($urandom), 1'b0);
        bus_op(0, 1, STAT, 16'h0, "t5_ferr_status");
        rx_glitch();
        bus_op(0, 1, STAT, 16'h0, "t5_glitch_status");
        bus_op(0, 1, BASE, 16'h0, "t5_glitch_data");

        // randomized mix
        repeat (70) begin
            case ($urandom_range(0, 7))
                0, 1: bus_op(1, 0, BASE, 16'($urandom), "");
                2: bus_op(0, 1, STAT, 16'h0, "rnd_status");
                3: bus_op(0, 1, BASE, 16'h0, "rnd_data");
                4: bus_op(1, 1, BASE, 16'($urandom), "rnd_wr_rd");
                5: bus_op(1, 1'($urandom), STAT, 16'($urandom), "rnd_stat_wr");
                6: rx_frame(8'($urandom), $urandom_range(0, 7) != 0);
                default: begin
                    bus_op(0, 1, 8'h40, 16'h0, "rnd_undecoded");
                    repeat ($urandom_range(0, 20)) tick();
                end
            endcase
        end
        wait_tx_idle();
        repeat (DEPTH + 1) bus_op(0, 1, BASE, 16'h0, "drain_data");
        bus_op(0, 1, STAT, 16'h0, "drain_status");

        // T6: reset in the middle of a frame
        bus_op(1, 0, BASE, {8'h00, 8'($urandom)}, "");
        repeat (10) tick();
        reset = 1'b1;
        rx_m.delete();
        ovr_m = 1'b0;
        ferr_m = 1'b0;
        tick();
        chk("t6_tx_after_reset", {31'h0, tx}, 32'h1);
        reset = 1'b0;
        tick();
        bus_op(0, 1, STAT, 16'h0, "t6_status");
        bus_op(1, 0, BASE, {8'h00, 8'hC3}, "");
        wait_tx_idle();
        bus_op(0, 1, STAT, 16'h0, "t6_final_status");

        repeat (4) tick();
        chk("tx_leftover", tx_exp.size(), 32'h0);
        chk("rd_leftover", rd_exp.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
